jamma_joy_scanner: RTL and testbench
====================================

JAMMA_JOY_SCANNER -- requirements
Module: jamma_joy_scanner

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of multiplexed players on the shared JAMMA bus (legal range 2..4).
REQ-002 SHALL have parameter JOY_W, default 8, bits per player (active-low buttons/directions).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, clocks allowed for the bus to settle after a select change (legal range 1..255).
REQ-004 SHALL have parameter DEBOUNCE, default 3, consecutive identical samples required to commit a value (legal range 1..7).
REQ-005 SHALL derive SEL_W = max(1, ceil(log2(NUM_PLAYERS))) internally; SEL_W is not overridable.
REQ-006 CLK  in  1  single clock for all logic.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 ENABLE  in  1  scan enable; low parks the scanner in IDLE.
REQ-009 JJOY  in  JOY_W  shared active-low input bus, valid for the player currently selected.
REQ-010 LOCAL_JOY  in  JOY_W  active-low on-board joystick, ANDed into the player 0 sample only.
REQ-011 JSELECT  out  SEL_W  registered player select driven to the external splitter.
REQ-012 JOY_OUT  out  NUM_PLAYERS*JOY_W  debounced active-low state; player p occupies bits [p*JOY_W +: JOY_W].
REQ-013 JOY_CHANGED  out  NUM_PLAYERS  one-cycle pulse per player when that player's JOY_OUT slice updates.
REQ-014 SCAN_DONE  out  1  one-cycle pulse when the last player has been sampled.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE; SAMPLE lasts exactly one clock.
REQ-016 IDLE: ENABLE=1 -> SETTLE with settle counter cleared; JSELECT unchanged.
REQ-017 SETTLE: counter increments each clock; counter==SETTLE_CYCLES-1 -> SAMPLE; ENABLE=0 -> IDLE immediately, counter cleared, JSELECT held.
REQ-018 SAMPLE: s = JJOY, or JJOY & LOCAL_JOY when JSELECT==0; JSELECT advances (NUM_PLAYERS-1 wraps to 0); next state SETTLE if ENABLE=1, else IDLE; an ENABLE drop during SAMPLE does not abort the sample.
REQ-019 Per-player period SHALL be SETTLE_CYCLES+1 clocks; a full scan SHALL take NUM_PLAYERS*(SETTLE_CYCLES+1) clocks.
REQ-020 Each player p SHALL hold candidate cand[p] (JOY_W bits) and a 3-bit count cnt[p].
REQ-021 On SAMPLE for player p: n = (s==cand[p]) ? min(cnt[p]+1, DEBOUNCE) : 1; cand[p] <= s; cnt[p] <= n.
REQ-022 If n==DEBOUNCE and s != JOY_OUT slice p, the slice SHALL load s and JOY_CHANGED[p] SHALL pulse; both are registered on the SAMPLE clock edge and are visible in the following cycle.
REQ-023 A sample equal to the committed value SHALL NOT pulse JOY_CHANGED; once saturated, cnt[p] stays at DEBOUNCE.
REQ-024 SCAN_DONE SHALL pulse on the same edge as the last-player SAMPLE (JSELECT wrap); it is otherwise 0.
REQ-025 JSELECT SHALL never take a value >= NUM_PLAYERS.
REQ-026 Players not selected SHALL retain cand, cnt and JOY_OUT unchanged.

Reset
REQ-027 RESET SHALL act immediately without a clock edge: state=IDLE, JSELECT=0, settle counter=0, JOY_OUT all ones, cand all ones, cnt all 0, JOY_CHANGED=0, SCAN_DONE=0.
REQ-028 After RESET deasserts with ENABLE=1, the first SAMPLE SHALL occur SETTLE_CYCLES+1 clocks after the first rising edge that sees RESET low.

Verification
REQ-029 Reset/cadence (defaults): RESET pulse, ENABLE=1, JJOY=FF, LOCAL_JOY=FF -> JOY_OUT=16'hFFFF; JSELECT toggles every 5 clocks; SCAN_DONE pulses every 10 clocks; JOY_CHANGED stays 0.
REQ-030 Debounce commit: JJOY=FE while JSELECT=1 for 3 consecutive scans -> JOY_OUT[15:8]=FE one cycle after the 3rd sample; JOY_CHANGED=2'b10 for exactly 1 cycle.
REQ-031 Glitch reject: JJOY=FE for 2 player-1 samples, then FF -> JOY_OUT[15:8] stays FF; no pulse.
REQ-032 Local merge: LOCAL_JOY=EF, JJOY=FF -> JOY_OUT[7:0]=EF after the 3rd player-0 sample; JOY_OUT[15:8]=FF.
REQ-033 Enable pause: ENABLE=0 on the 2nd SETTLE clock -> IDLE, JSELECT held; ENABLE=1 again -> that player is sampled 5 clocks later.
REQ-034 NUM_PLAYERS=3, SETTLE_CYCLES=1, DEBOUNCE=1 -> JSELECT sequence 0,1,2,0 (SEL_W=2, value 3 never appears); a single differing sample commits at once; RESET asserted mid-SETTLE clears all outputs asynchronously.

Source files
------------

// File: rtl/jamma_joy_scanner.sv
// jamma_joy_scanner: time-multiplexes one shared active-low JAMMA joystick
// bus across NUM_PLAYERS players, debounces each player and flags changes.
// Ports:
//   clk_i          clock
//   rst_i          async active-high reset
//   enable_i       scan enable (low parks the scanner)
//   jjoy_i         shared active-low bus for the selected player
//   local_joy_i    on-board joystick, merged into player 0 only
//   jselect_o      registered player select to the external splitter
//   joy_out_o      debounced state, player p at [p*JOY_W +: JOY_W]
//   joy_changed_o  one-cycle pulse per player on a committed update
//   scan_done_o    one-cycle pulse when the last player is sampled
module jamma_joy_scanner #(
   parameter int NUM_PLAYERS   = 2,
   parameter int JOY_W         = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int DEBOUNCE      = 3,
   localparam int SEL_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic [JOY_W-1:0]             jjoy_i,
   input  logic [JOY_W-1:0]             local_joy_i,
   output logic [SEL_W-1:0]             jselect_o,
   output logic [NUM_PLAYERS*JOY_W-1:0] joy_out_o,
   output logic [NUM_PLAYERS-1:0]       joy_changed_o,
   output logic                         scan_done_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;

   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       DEB         = 3'(DEBOUNCE);
   localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_PLAYERS - 1);

   logic [1:0]                   state_q, state_d;
   logic [7:0]                   settle_q, settle_d;
   logic [SEL_W-1:0]             sel_q, sel_d;
   logic [JOY_W-1:0]             cand_q [NUM_PLAYERS];
   logic [2:0]                   cnt_q  [NUM_PLAYERS];
   logic [NUM_PLAYERS*JOY_W-1:0] joy_q;
   logic [NUM_PLAYERS-1:0]       chg_q, chg_d;
   logic                         done_q, done_d;

   logic [JOY_W-1:0] samp;
   logic [JOY_W-1:0] cand_cur;
   logic [JOY_W-1:0] joy_cur;
   logic [2:0]       cnt_cur;
   logic [2:0]       cnt_new;
   logic             do_sample;
   logic             commit;

   // Scan sequencing: SETTLE waits for the splitter, SAMPLE is one clock.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      sel_d     = sel_q;
      do_sample = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (!enable_i) begin
               state_d  = ST_IDLE;
               settle_d = '0;
            end else if (settle_q == SETTLE_LAST) begin
               state_d  = ST_SAMPLE;
               settle_d = '0;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         ST_SAMPLE: begin
            // The sample always completes, even if enable just dropped.
            do_sample = 1'b1;
            settle_d  = '0;
            sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            state_d   = enable_i ? ST_SETTLE : ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            settle_d = '0;
         end
      endcase
   end

   // Debounce datapath for the currently selected player.
   always_comb begin
      samp = jjoy_i;
      if (sel_q == '0) samp = jjoy_i & local_joy_i;
      cand_cur = '1;
      cnt_cur  = '0;
      joy_cur  = '1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (sel_q == SEL_W'(p)) begin
            cand_cur = cand_q[p];
            cnt_cur  = cnt_q[p];
            joy_cur  = joy_q[p*JOY_W +: JOY_W];
         end
      end
      if (samp != cand_cur)   cnt_new = 3'd1;
      else if (cnt_cur >= DEB) cnt_new = DEB;
      else                    cnt_new = cnt_cur + 3'd1;
      commit = do_sample && (cnt_new == DEB) && (samp != joy_cur);
      done_d = do_sample && (sel_q == SEL_LAST);
      chg_d  = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         chg_d[p] = commit && (sel_q == SEL_W'(p));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         sel_q    <= '0;
         joy_q    <= '1;
         chg_q    <= '0;
         done_q   <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            cand_q[p] <= '1;
            cnt_q[p]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         sel_q    <= sel_d;
         chg_q    <= chg_d;
         done_q   <= done_d;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (do_sample && (sel_q == SEL_W'(p))) begin
               cand_q[p] <= samp;
               cnt_q[p]  <= cnt_new;
               if (commit) joy_q[p*JOY_W +: JOY_W] <= samp;
            end
         end
      end
   end

   assign jselect_o     = sel_q;
   assign joy_out_o     = joy_q;
   assign joy_changed_o = chg_q;
   assign scan_done_o   = done_q;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb_jamma_joy_scanner: scoreboard bench for two scanner configurations
// (defaults, and 3 players / settle 1 / debounce 1) sharing one stimulus.
module tb_jamma_joy_scanner;

   typedef struct {
      int          tag;
      logic [1:0]  sel;
      logic [31:0] out;
      logic [3:0]  chg;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  jj;
   logic [7:0]  lj;

   logic        jsel_a;
   logic [15:0] out_a;
   logic [1:0]  chg_a;
   logic        done_a;
   logic [1:0]  jsel_b;
   logic [23:0] out_b;
   logic [2:0]  chg_b;
   logic        done_b;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   exp_t q0[$];
   exp_t q1[$];

   int         np_c [2] = '{2, 3};
   int         st_c [2] = '{4, 1};
   int         db_c [2] = '{3, 1};
   bit         parked [2];
   int         to_go  [2];
   int         sel_m  [2];
   logic [7:0] outv   [2][4];
   logic [7:0] lastv  [2][4];
   int         run    [2][4];

   jamma_joy_scanner u_a (
      .clk_i(clk), .rst_i(rst), .enable_i(en),
      .jjoy_i(jj), .local_joy_i(lj),
      .jselect_o(jsel_a), .joy_out_o(out_a),
      .joy_changed_o(chg_a), .scan_done_o(done_a)
   );

   jamma_joy_scanner #(
      .NUM_PLAYERS(3), .JOY_W(8), .SETTLE_CYCLES(1), .DEBOUNCE(1)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .enable_i(en),
      .jjoy_i(jj), .local_joy_i(lj),
      .jselect_o(jsel_b), .joy_out_o(out_b),
      .joy_changed_o(chg_b), .scan_done_o(done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, want);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         parked[c] = 1'b1;
         to_go[c]  = 0;
         sel_m[c]  = 0;
         for (int p = 0; p < 4; p++) begin
            outv[c][p]  = 8'hFF;
            lastv[c][p] = 8'hFF;
            run[c][p]   = 0;
         end
      end
   endtask

   // to_go: edges left before the next sample edge while scanning.
   function automatic exp_t model_step(int c, logic e_, logic [7:0] j,
                                       logic [7:0] l);
      exp_t       r;
      logic [7:0] s;
      int         p;
      r.chg  = '0;
      r.done = 1'b0;
      if (parked[c]) begin
         if (e_) begin
            parked[c] = 1'b0;
            to_go[c]  = st_c[c];
         end
      end else if (to_go[c] == 0) begin
         p = sel_m[c];
         s = (p == 0) ? (j & l) : j;
         run[c][p]   = (s == lastv[c][p]) ? run[c][p] + 1 : 1;
         lastv[c][p] = s;
         if (run[c][p] >= db_c[c] && s != outv[c][p]) begin
            outv[c][p] = s;
            r.chg[p]   = 1'b1;
         end
         r.done   = (p == np_c[c] - 1);
         sel_m[c] = (p + 1) % np_c[c];
         if (e_) to_go[c] = st_c[c];
         else    parked[c] = 1'b1;
      end else if (!e_) begin
         parked[c] = 1'b1;
      end else begin
         to_go[c] = to_go[c] - 1;
      end
      r.sel = 2'(sel_m[c]);
      r.out = '0;
      for (int k = 0; k < np_c[c]; k++) r.out[k*8 +: 8] = outv[c][k];
      r.tag = edge_n + 1;
      return r;
   endfunction

   task automatic step(input logic e_, input logic [7:0] j,
                       input logic [7:0] l);
      exp_t r;
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = e_;
      jj  = j;
      lj  = l;
      r = model_step(0, e_, j, l);
      q0.push_back(r);
      r = model_step(1, e_, j, l);
      q1.push_back(r);
   endtask

   task automatic chk_rst(input string tg);
      cmp({tg, "_a_sel"},  {31'b0, jsel_a}, 32'd0);
      cmp({tg, "_a_out"},  {16'b0, out_a},  32'h0000FFFF);
      cmp({tg, "_a_chg"},  {30'b0, chg_a},  32'd0);
      cmp({tg, "_a_done"}, {31'b0, done_a}, 32'd0);
      cmp({tg, "_b_sel"},  {30'b0, jsel_b}, 32'd0);
      cmp({tg, "_b_out"},  {8'b0, out_b},   32'h00FFFFFF);
      cmp({tg, "_b_chg"},  {29'b0, chg_b},  32'd0);
      cmp({tg, "_b_done"}, {31'b0, done_b}, 32'd0);
   endtask

   task automatic mon(input int c);
      exp_t        e;
      bit          have;
      logic [31:0] as, ao, ac, ad;
      string       px;
      have = 1'b0;
      if (c == 0) begin
         px = "a";
         as = {31'b0, jsel_a}; ao = {16'b0, out_a};
         ac = {30'b0, chg_a};  ad = {31'b0, done_a};
         if (q0.size() > 0 && q0[0].tag < edge_n) begin
            checks++; errors++;
            $display("FAIL a_stale got tag %0d want %0d", q0[0].tag, edge_n);
            void'(q0.pop_front());
         end
         if (q0.size() > 0 && q0[0].tag == edge_n) begin
            e = q0.pop_front(); have = 1'b1;
         end
      end else begin
         px = "b";
         as = {30'b0, jsel_b}; ao = {8'b0, out_b};
         ac = {29'b0, chg_b};  ad = {31'b0, done_b};
         cmp("b_sel_range", {31'b0, jsel_b == 2'd3}, 32'd0);
         if (q1.size() > 0 && q1[0].tag < edge_n) begin
            checks++; errors++;
            $display("FAIL b_stale got tag %0d want %0d", q1[0].tag, edge_n);
            void'(q1.pop_front());
         end
         if (q1.size() > 0 && q1[0].tag == edge_n) begin
            e = q1.pop_front(); have = 1'b1;
         end
      end
      if (have) begin
         cmp($sformatf("%s_sel@%0d", px, edge_n),  as, {30'b0, e.sel});
         cmp($sformatf("%s_out@%0d", px, edge_n),  ao, e.out);
         cmp($sformatf("%s_chg@%0d", px, edge_n),  ac, {28'b0, e.chg});
         cmp($sformatf("%s_done@%0d", px, edge_n), ad, {31'b0, e.done});
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      logic       en_r;
      logic [7:0] jj_r;
      logic [7:0] lj_r;
      int         n1;
      bit         smp1;
      rst = 1'b1;
      en  = 1'b0;
      jj  = 8'hFF;
      lj  = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_rst("por");

      // idle bus: cadence only, no changes
      repeat (40) step(1'b1, 8'hFF, 8'hFF);

      // player 1 holds FE over three scans, then releases
      repeat (30) step(1'b1, (sel_m[0] == 1) ? 8'hFE : 8'hFF, 8'hFF);
      repeat (30) step(1'b1, 8'hFF, 8'hFF);

      // glitch: exactly two player-1 samples of FE
      n1 = 0;
      for (int k = 0; k < 25; k++) begin
         smp1 = !parked[0] && to_go[0] == 0 && sel_m[0] == 1;
         step(1'b1, (n1 < 2) ? 8'hFE : 8'hFF, 8'hFF);
         if (smp1) n1++;
      end
      repeat (20) step(1'b1, 8'hFF, 8'hFF);

      // local joystick merged into player 0
      repeat (40) step(1'b1, 8'hFF, 8'hEF);
      repeat (40) step(1'b1, 8'hFF, 8'hFF);

      // enable drop on the second settle clock
      for (int k = 0; k < 20; k++) begin
         if (!parked[0] && to_go[0] == 3) break;
         step(1'b1, 8'hFF, 8'hFF);
      end
      repeat (3) step(1'b0, 8'hFF, 8'hFF);
      repeat (20) step(1'b1, (sel_m[0] == 0) ? 8'hDF : 8'hFF, 8'hFF);

      // async reset while the 3-player instance is settling
      for (int k = 0; k < 10; k++) begin
         if (!parked[1] && to_go[1] == 1) break;
         step(1'b1, 8'($urandom), 8'hFF);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_rst("async");
      q0.delete();
      q1.delete();
      model_reset();
      repeat (2) @(posedge clk);

      // randomized traffic
      en_r = 1'b1;
      jj_r = 8'hFF;
      lj_r = 8'hFF;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(11) == 0) begin
            case ($urandom_range(3))
               0:       jj_r = 8'hFF;
               1:       jj_r = 8'hFE;
               2:       jj_r = 8'h7F;
               default: jj_r = 8'($urandom);
            endcase
         end
         if ($urandom_range(39) == 0)
            lj_r = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
         if (en_r) begin
            if ($urandom_range(29) == 0) en_r = 1'b0;
         end else begin
            if ($urandom_range(3) == 0) en_r = 1'b1;
         end
         step(en_r, jj_r, lj_r);
      end
      repeat (3) step(1'b1, 8'hFF, 8'hFF);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
